peridot_board_i2c_regctl: RTL
=============================

// Module: peridot_board_i2c_regctl
// PURPOSE
//  I2C-slave transaction controller that sequences the board I2C byte engine.
//  Decodes the 7-bit device address and keeps an 8-bit register pointer.
//  Turns I2C write/read bursts into single-beat Avalon-MM master accesses.
//  Stretches SCL through the byte engine's ackwaitrequest while a bus access is pending.
// PARAMETERS
//  DEVICE_ADDR     7'h55  7-bit slave address this block answers to
//  AUTO_INCREMENT  1      1: pointer +1 per data byte (8-bit wrap); 0: pointer fixed
// PORTS
//  clock_sig           in   1  clock, all logic posedge
//  reset_sig           in   1  asynchronous, active-high reset
//  condi_start         in   1  pulse: START or repeated START seen by byte engine
//  condi_stop          in   1  pulse: STOP seen
//  done_byte           in   1  pulse: 8 bits shifted; recieve_bytedata valid
//  done_ack            in   1  pulse: ACK slot finished (SCL fall)
//  recieve_bytedata    in   8  byte received from master
//  recieve_ackdata     in   1  1 = master ACKed the byte we sent
//  ackwaitrequest      out  1  1 = hold SCL low in ACK slot
//  send_ackdata        out  1  1 = slave ACKs (pulls SDA) in ACK slot
//  send_bytedata       out  8  next byte to transmit
//  send_bytedatavalid  out  1  send_bytedata loaded at done_ack when 1, else 8'hFF
//  avm_address         out  8  register address (= pointer)
//  avm_read            out  1  Avalon read request
//  avm_write           out  1  Avalon write request
//  avm_writedata       out  8  write data
//  avm_readdata        in   8  read data, valid when avm_read && !avm_waitrequest
//  avm_waitrequest     in   1  Avalon wait
//  busy                out  1  1 while not in IDLE
// BEHAVIOUR
//  Reset values:
//   - all outputs 0; state IDLE; pointer 8'h00.
//  ackwaitrequest:
//   - registered; set the cycle after done_byte whenever a bus access is required.
//   - cleared the cycle after the access completes (!avm_waitrequest).
//   - held 0 when no access is required.
//  Avalon:
//   - avm_read/avm_write held with stable address/data until !avm_waitrequest, then dropped.
//   - a started transfer is never aborted; START/STOP arriving meanwhile is latched.
//   - the latched START/STOP is applied in the cycle after completion.
//  FSM (condi_start from any state -> DEVADDR; condi_stop -> IDLE; pointer kept in both cases):
//   IDLE:
//    - ignore done_byte; send_ackdata=0.
//   DEVADDR (on done_byte):
//    - byte[7:1]!=DEVICE_ADDR: send_ackdata=0 -> IGNORE.
//    - match and byte[0]=0: send_ackdata=1 -> REGADDR.
//    - match and byte[0]=1: send_ackdata=1; read mem[pointer] into send_bytedata, valid=1;
//      pointer+=AUTO_INCREMENT; ackwaitrequest until readdata captured -> RDDATA.
//   REGADDR (on done_byte):
//    - pointer<=byte; send_ackdata=1 -> WRDATA.
//   WRDATA (on done_byte):
//    - avm_write mem[pointer]<=byte; ackwaitrequest held until accepted.
//    - send_ackdata=1; pointer+=AUTO_INCREMENT.
//   RDDATA:
//    - send_ackdata=0 always (SDA released in master's ACK slot).
//    - on done_byte: prefetch mem[pointer] with ackwaitrequest held; pointer+=AUTO_INCREMENT.
//    - on done_ack with recieve_ackdata=0 (NACK): send_bytedatavalid<=0 -> IGNORE.
//   IGNORE:
//    - send_ackdata=0, send_bytedatavalid=0, no bus access; wait for START/STOP.
//  Boundaries:
//   - pointer 8'hFF +1 -> 8'h00.
//   - condi_start and condi_stop never coincide; if both, STOP wins.
//   - done_byte while an access is in flight cannot occur (SCL is stretched).
//   - reset mid-transfer drops avm_read/avm_write immediately (system reset only).
//   - prefetch side effect: the byte after a NACKed read is read on the bus but discarded.
// TESTING
//  1. W 0xAA(0x55,W), 0x10, 0x3C, 0x5A, STOP -> ACK x4; writes 0x10<=3C, 0x11<=5A; ptr 0x12.
//  2. W 0xAA, 0x20; Sr; 0xAB; read 2 bytes, ACK then NACK -> reads addr 0x20,0x21,0x22;
//     SDA returns mem[0x20],mem[0x21]; then 0xFF.
//  3. Address 0x90 (0x48) -> NACK; no avm_read/avm_write until next START; busy high until STOP.
//  4. avm_waitrequest held 50 cycles on a write -> ackwaitrequest=1 throughout, SCL low;
//     release 1 cycle after accept.
//  5. Pointer 0xFF, write 2 bytes -> addresses 0xFF then 0x00; AUTO_INCREMENT=0 -> both 0xFF.
//  6. reset_sig asserted during avm_read -> outputs 0, state IDLE; next transaction correct.

Source files
------------

// File: rtl/peridot_board_i2c_regctl.sv
`timescale 1ns/1ps
// I2C-slave register controller: sequences the board byte engine and turns
// I2C write/read bursts into single-beat Avalon-MM accesses via an 8-bit pointer.
module peridot_board_i2c_regctl #(
    parameter logic [6:0]  DEVICE_ADDR    = 7'h55,
    parameter int unsigned AUTO_INCREMENT = 1
) (
    input  logic       clock_sig,
    input  logic       reset_sig,
    input  logic       condi_start,
    input  logic       condi_stop,
    input  logic       done_byte,
    input  logic       done_ack,
    input  logic [7:0] recieve_bytedata,
    input  logic       recieve_ackdata,
    output logic       ackwaitrequest,
    output logic       send_ackdata,
    output logic [7:0] send_bytedata,
    output logic       send_bytedatavalid,
    output logic [7:0] avm_address,
    output logic       avm_read,
    output logic       avm_write,
    output logic [7:0] avm_writedata,
    input  logic [7:0] avm_readdata,
    input  logic       avm_waitrequest,
    output logic       busy
);
    localparam int unsigned BYTE_W = 8;
    localparam logic [BYTE_W-1:0] PTR_INC = (AUTO_INCREMENT != 0) ? BYTE_W'(1) : BYTE_W'(0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEVADDR,
        ST_REGADDR,
        ST_WRDATA,
        ST_RDDATA,
        ST_IGNORE
    } state_t;

    state_t            state_q, state_d;
    logic [BYTE_W-1:0] ptr_q, ptr_d;
    logic              pend_start_q, pend_start_d;
    logic              pend_stop_q, pend_stop_d;
    logic              rd_first_q, rd_first_d;
    logic              ackwaitrequest_d, send_ackdata_d, send_bytedatavalid_d;
    logic              avm_read_d, avm_write_d, busy_d;
    logic [BYTE_W-1:0] send_bytedata_d, avm_address_d, avm_writedata_d;
    logic              acc_busy, acc_done, ev_stop, ev_start, addr_match;

    // Bus conditions are deferred while an access is in flight; STOP beats START.
    assign acc_busy   = avm_read | avm_write;
    assign acc_done   = acc_busy & ~avm_waitrequest;
    assign ev_stop    = ~acc_busy & (condi_stop | pend_stop_q);
    assign ev_start   = ~acc_busy & ~ev_stop & (condi_start | pend_start_q);
    assign addr_match = (recieve_bytedata[7:1] == DEVICE_ADDR);

    // State register
    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (ev_stop) begin
            state_d = ST_IDLE;
        end else if (ev_start) begin
            state_d = ST_DEVADDR;
        end else if (!acc_busy) begin
            case (state_q)
                ST_DEVADDR: begin
                    if (done_byte) begin
                        if (!addr_match)              state_d = ST_IGNORE;
                        else if (recieve_bytedata[0]) state_d = ST_RDDATA;
                        else                          state_d = ST_REGADDR;
                    end
                end
                ST_REGADDR: if (done_byte) state_d = ST_WRDATA;
                ST_RDDATA: begin
                    if (done_ack && !rd_first_q && !recieve_ackdata) state_d = ST_IGNORE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        ptr_d                = ptr_q;
        pend_start_d         = 1'b0;
        pend_stop_d          = 1'b0;
        rd_first_d           = rd_first_q;
        ackwaitrequest_d     = ackwaitrequest;
        send_ackdata_d       = send_ackdata;
        send_bytedata_d      = send_bytedata;
        send_bytedatavalid_d = send_bytedatavalid;
        avm_address_d        = avm_address;
        avm_read_d           = avm_read;
        avm_write_d          = avm_write;
        avm_writedata_d      = avm_writedata;
        busy_d               = (state_d != ST_IDLE);

        if (acc_busy) begin
            pend_start_d = pend_start_q | condi_start;
            pend_stop_d  = pend_stop_q | condi_stop;
        end

        if (acc_done) begin
            avm_read_d       = 1'b0;
            avm_write_d      = 1'b0;
            ackwaitrequest_d = 1'b0;
            if (avm_read) begin
                send_bytedata_d      = avm_readdata;
                send_bytedatavalid_d = 1'b1;
            end
        end

        if (ev_stop || ev_start) begin
            send_ackdata_d       = 1'b0;
            send_bytedatavalid_d = 1'b0;
            rd_first_d           = 1'b0;
        end else if (!acc_busy) begin
            case (state_q)
                ST_IDLE: send_ackdata_d = 1'b0;
                ST_DEVADDR: begin
                    if (done_byte) begin
                        send_ackdata_d = addr_match;
                        if (addr_match && recieve_bytedata[0]) begin
                            avm_read_d       = 1'b1;
                            avm_address_d    = ptr_q;
                            ackwaitrequest_d = 1'b1;
                            ptr_d            = ptr_q + PTR_INC;
                            rd_first_d       = 1'b1;
                        end
                    end
                end
                ST_REGADDR: begin
                    if (done_byte) begin
                        ptr_d          = recieve_bytedata;
                        send_ackdata_d = 1'b1;
                    end
                end
                ST_WRDATA: begin
                    if (done_byte) begin
                        avm_write_d      = 1'b1;
                        avm_address_d    = ptr_q;
                        avm_writedata_d  = recieve_bytedata;
                        ackwaitrequest_d = 1'b1;
                        send_ackdata_d   = 1'b1;
                        ptr_d            = ptr_q + PTR_INC;
                    end
                end
                ST_RDDATA: begin
                    // The first ACK slot here is our own address ACK, not the master's.
                    if (done_ack) begin
                        send_ackdata_d = 1'b0;
                        rd_first_d     = 1'b0;
                        if (!rd_first_q && !recieve_ackdata) send_bytedatavalid_d = 1'b0;
                    end
                    if (done_byte) begin
                        send_ackdata_d   = 1'b0;
                        avm_read_d       = 1'b1;
                        avm_address_d    = ptr_q;
                        ackwaitrequest_d = 1'b1;
                        ptr_d            = ptr_q + PTR_INC;
                    end
                end
                ST_IGNORE: begin
                    send_ackdata_d       = 1'b0;
                    send_bytedatavalid_d = 1'b0;
                end
                default: send_ackdata_d = 1'b0;
            endcase
        end
    end

    // Output and datapath registers
    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            ptr_q              <= '0;
            pend_start_q       <= 1'b0;
            pend_stop_q        <= 1'b0;
            rd_first_q         <= 1'b0;
            ackwaitrequest     <= 1'b0;
            send_ackdata       <= 1'b0;
            send_bytedata      <= '0;
            send_bytedatavalid <= 1'b0;
            avm_address        <= '0;
            avm_read           <= 1'b0;
            avm_write          <= 1'b0;
            avm_writedata      <= '0;
            busy               <= 1'b0;
        end else begin
            ptr_q              <= ptr_d;
            pend_start_q       <= pend_start_d;
            pend_stop_q        <= pend_stop_d;
            rd_first_q         <= rd_first_d;
            ackwaitrequest     <= ackwaitrequest_d;
            send_ackdata       <= send_ackdata_d;
            send_bytedata      <= send_bytedata_d;
            send_bytedatavalid <= send_bytedatavalid_d;
            avm_address        <= avm_address_d;
            avm_read           <= avm_read_d;
            avm_write          <= avm_write_d;
            avm_writedata      <= avm_writedata_d;
            busy               <= busy_d;
        end
    end

endmodule
